// File: rtl/pwm_capture_pkg.sv
// Shared constants and helpers for the PWM capture block and the edge-input plugins.
package pwm_capture_pkg;

  localparam int SYNC_STAGES = 2;

  // Increment that sticks at maxValue so that long gaps never wrap back to small counts.
  function automatic logic [31:0] satInc(input logic [31:0] value, input logic [31:0] maxValue);
    return (value >= maxValue) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// Synchronises an asynchronous pin and flags its rising and falling edges one cycle wide.
module pwm_edge_sync
  import pwm_capture_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   delayed_q;
  logic                   syncLevel;

  assign syncLevel = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q    <= '0;
      delayed_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], pin_i};
      delayed_q <= syncLevel;
    end
  end

  assign level_o = syncLevel;
  assign rise_o  = syncLevel & ~delayed_q;
  assign fall_o  = ~syncLevel & delayed_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an external PWM signal, rise to rise, in clk cycles.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int BITS    = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            pwm_in,
  output logic [BITS-1:0] period,
  output logic [BITS-1:0] high_time,
  output logic            valid,
  output logic            stall,
  output logic            level
);

  localparam logic [BITS-1:0] TimeoutCount = BITS'(TIMEOUT);
  localparam logic [BITS-1:0] CountMax     = '1;
  localparam logic [BITS-1:0] CountOne     = BITS'(1);

  logic            pinLevel;
  logic            pinRise;
  logic [BITS-1:0] cntPeriod_q, cntPeriod_d;
  logic [BITS-1:0] cntHigh_q, cntHigh_d;
  logic [BITS-1:0] period_q, period_d;
  logic [BITS-1:0] highTime_q, highTime_d;
  logic            armed_q, armed_d;
  logic            stall_q, stall_d;
  logic            valid_q, valid_d;

  pwm_edge_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .pin_i   (pwm_in),
    .level_o (pinLevel),
    .rise_o  (pinRise),
    .fall_o  ()
  );

  // A rise wins over a coincident timeout; only the first timeout of a stall strobes valid.
  always_comb begin
    cntPeriod_d = BITS'(satInc(32'(cntPeriod_q), 32'(CountMax)));
    cntHigh_d   = pinLevel ? BITS'(satInc(32'(cntHigh_q), 32'(CountMax))) : cntHigh_q;
    period_d    = period_q;
    highTime_d  = highTime_q;
    armed_d     = armed_q;
    stall_d     = stall_q;
    valid_d     = 1'b0;
    if (pinRise) begin
      cntPeriod_d = CountOne;
      cntHigh_d   = CountOne;
      armed_d     = 1'b1;
      if (armed_q) begin
        period_d   = cntPeriod_q;
        highTime_d = cntHigh_q;
        valid_d    = 1'b1;
        stall_d    = 1'b0;
      end
    end else if (cntPeriod_q == TimeoutCount) begin
      armed_d    = 1'b0;
      stall_d    = 1'b1;
      period_d   = '0;
      highTime_d = '0;
      valid_d    = ~stall_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cntPeriod_q <= '0;
      cntHigh_q   <= '0;
      period_q    <= '0;
      highTime_q  <= '0;
      armed_q     <= 1'b0;
      stall_q     <= 1'b1;
      valid_q     <= 1'b0;
    end else begin
      cntPeriod_q <= cntPeriod_d;
      cntHigh_q   <= cntHigh_d;
      period_q    <= period_d;
      highTime_q  <= highTime_d;
      armed_q     <= armed_d;
      stall_q     <= stall_d;
      valid_q     <= valid_d;
    end
  end

  assign period    = period_q;
  assign high_time = highTime_q;
  assign valid     = valid_q;
  assign stall     = stall_q;
  assign level     = pinLevel;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: a 16-bit instance (TIMEOUT=300) and an 8-bit one (TIMEOUT=200).
module tb_pwm_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN16, rstN8, pwm16, pwm8;
  logic [15:0] period16, highTime16;
  logic        valid16, stall16, level16;
  logic [7:0]  period8, highTime8;
  logic        valid8, stall8, level8;

  int          checks = 0;
  int          errors = 0;
  int          validCount;
  logic [15:0] lastPeriod, lastHigh;

  pwm_capture #(.BITS(16), .TIMEOUT(300)) dut16 (
    .clk(clk), .reset_n(rstN16), .pwm_in(pwm16), .period(period16), .high_time(highTime16),
    .valid(valid16), .stall(stall16), .level(level16)
  );

  pwm_capture #(.BITS(8), .TIMEOUT(200)) dut8 (
    .clk(clk), .reset_n(rstN8), .pwm_in(pwm8), .period(period8), .high_time(highTime8),
    .valid(valid8), .stall(stall8), .level(level8)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One waveform window: pin high for highCycles then low; records strobes seen during the window.
  task automatic applyStimulus(input bit sel, input int highCycles, input int totalCycles, input int resetAt);
    validCount = 0;
    for (int k = 0; k < totalCycles; k++) begin
      @(posedge clk);
      #1;
      if (sel ? valid8 : valid16) begin
        validCount++;
        lastPeriod = sel ? {8'h00, period8} : period16;
        lastHigh   = sel ? {8'h00, highTime8} : highTime16;
      end
      #($urandom_range(1, 3));
      if (sel) pwm8 = (k < highCycles);
      else     pwm16 = (k < highCycles);
      if (resetAt >= 0 && k == resetAt)     rstN16 = 1'b0;
      if (resetAt >= 0 && k == resetAt + 1) rstN16 = 1'b1;
    end
  endtask

  initial begin
    rstN16 = 1'b0;
    rstN8  = 1'b0;
    pwm16  = 1'b0;
    pwm8   = 1'b0;
    lastPeriod = '0;
    lastHigh   = '0;

    repeat (5) @(posedge clk);
    #1;
    rstN16 = 1'b1;
    rstN8  = 1'b1;
    @(posedge clk);
    #1;
    $display("[TB] reset state");
    checkOutput("rst_period", 32'(period16), 0);
    checkOutput("rst_high", 32'(highTime16), 0);
    checkOutput("rst_stall", 32'(stall16), 1);
    checkOutput("rst_valid", 32'(valid16), 0);
    checkOutput("rst_level", 32'(level16), 0);
    checkOutput("rst8_stall", 32'(stall8), 1);

    $display("[TB] steady 100/25");
    applyStimulus(0, 25, 100, -1);
    checkOutput("first_rise_nvalid", validCount, 0);
    checkOutput("first_rise_stall", 32'(stall16), 1);
    applyStimulus(0, 25, 100, -1);
    checkOutput("second_rise_nvalid", validCount, 1);
    checkOutput("second_rise_period", 32'(lastPeriod), 100);
    checkOutput("second_rise_high", 32'(lastHigh), 25);
    checkOutput("running_stall", 32'(stall16), 0);
    applyStimulus(0, 25, 100, -1);
    checkOutput("steady_period", 32'(lastPeriod), 100);
    checkOutput("steady_high", 32'(lastHigh), 25);

    $display("[TB] duty step 25 -> 75");
    applyStimulus(0, 75, 100, -1);
    checkOutput("step_nvalid", validCount, 1);
    checkOutput("step_prev_high", 32'(lastHigh), 25);
    applyStimulus(0, 75, 100, -1);
    checkOutput("step_nvalid2", validCount, 1);
    checkOutput("step_period", 32'(lastPeriod), 100);
    checkOutput("step_high", 32'(lastHigh), 75);
    applyStimulus(0, 25, 100, -1);
    checkOutput("step_back_high", 32'(lastHigh), 75);

    $display("[TB] pin held high past timeout");
    applyStimulus(0, 400, 400, -1);
    checkOutput("hold_nvalid", validCount, 2);
    checkOutput("hold_period", 32'(lastPeriod), 0);
    checkOutput("hold_high", 32'(lastHigh), 0);
    checkOutput("hold_stall", 32'(stall16), 1);
    checkOutput("hold_level", 32'(level16), 1);
    applyStimulus(0, 0, 10, -1);
    applyStimulus(0, 25, 100, -1);
    checkOutput("resume_first_nvalid", validCount, 0);
    checkOutput("resume_first_stall", 32'(stall16), 1);
    applyStimulus(0, 25, 100, -1);
    checkOutput("resume_nvalid", validCount, 1);
    checkOutput("resume_period", 32'(lastPeriod), 100);
    checkOutput("resume_high", 32'(lastHigh), 25);
    checkOutput("resume_stall", 32'(stall16), 0);

    $display("[TB] reset mid-period");
    applyStimulus(0, 25, 100, 50);
    checkOutput("midrst_period", 32'(period16), 0);
    checkOutput("midrst_high", 32'(highTime16), 0);
    checkOutput("midrst_stall", 32'(stall16), 1);
    checkOutput("midrst_valid", 32'(valid16), 0);
    checkOutput("midrst_level", 32'(level16), 0);
    applyStimulus(0, 25, 100, -1);
    checkOutput("midrst_first_nvalid", validCount, 0);
    applyStimulus(0, 25, 100, -1);
    checkOutput("midrst_nvalid", validCount, 1);
    checkOutput("midrst_new_period", 32'(lastPeriod), 100);
    checkOutput("midrst_new_high", 32'(lastHigh), 25);

    $display("[TB] 8-bit instance");
    applyStimulus(1, 40, 150, -1);
    checkOutput("b8_first_nvalid", validCount, 0);
    applyStimulus(1, 40, 150, -1);
    checkOutput("b8_nvalid", validCount, 1);
    checkOutput("b8_period", 32'(lastPeriod), 150);
    checkOutput("b8_high", 32'(lastHigh), 40);
    applyStimulus(1, 40, 150, -1);
    checkOutput("b8_period2", 32'(lastPeriod), 150);
    applyStimulus(1, 40, 255, -1);
    checkOutput("b8_long_nvalid", validCount, 2);
    checkOutput("b8_long_period", 32'(lastPeriod), 0);
    checkOutput("b8_long_high", 32'(lastHigh), 0);
    checkOutput("b8_long_stall", 32'(stall8), 1);
    applyStimulus(1, 40, 255, -1);
    checkOutput("b8_nowrap_nvalid", validCount, 0);
    checkOutput("b8_nowrap_period", 32'(period8), 0);
    checkOutput("b8_nowrap_stall", 32'(stall8), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
